// File: rtl/clock_pkg.sv
// Shared constants for the digital clock time-unit stages.
// Widths, moduli and count direction encodings.
package clock_pkg;

    localparam int CNT_W       = 6;
    localparam int SEC_MIN_MOD = 60;
    localparam int HOUR_MOD    = 24;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic bit modulus_ok(input int w, input int m);
        return (m >= 2) && (w < 31) && (m <= (1 << w));
    endfunction

endpackage

// File: rtl/mod_counter_cmp_terminal_compare.sv
// Combinational equality of a counter value to a fixed constant.
// Used for both the up-count and down-count terminal values.
module terminal_compare #(
    parameter int WIDTH = 6,
    parameter int VALUE = 0
) (
    input  logic [WIDTH-1:0] value,
    output logic             match
);

    localparam logic [WIDTH-1:0] TARGET = WIDTH'(VALUE);

    assign match = (value == TARGET);

endmodule

// File: rtl/mod_counter_cmp.sv
// Modulo-N up/down counter with terminal-count detect and carry ripple.
// Synchronous load with sticky out-of-range error flag.
module mod_counter_cmp
    import clock_pkg::*;
#(
    parameter int WIDTH   = CNT_W,
    parameter int MODULUS = SEC_MIN_MOD,
    parameter int DOWN_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             carry,
    output logic             err
);

    generate
        if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
            $fatal(1, "mod_counter_cmp: MODULUS out of range for WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic             dir;
    logic             at_max;
    logic             at_zero;
    logic             load_ok;
    logic [WIDTH-1:0] count_nx;
    logic             err_nx;

    assign dir = (DOWN_EN != 0) ? up : DIR_UP;

    terminal_compare #(
        .WIDTH(WIDTH),
        .VALUE(MODULUS - 1)
    ) u_cmp_max (
        .value(count),
        .match(at_max)
    );

    terminal_compare #(
        .WIDTH(WIDTH),
        .VALUE(0)
    ) u_cmp_zero (
        .value(count),
        .match(at_zero)
    );

    assign tc      = dir ? at_max : at_zero;
    // A set operation must never ripple into the next stage.
    assign carry   = en & tc & ~load;
    assign load_ok = (32'(load_val) < MODULUS);

    always_comb begin
        count_nx = count;
        err_nx   = err;
        if (load) begin
            if (load_ok) begin
                count_nx = load_val;
            end else begin
                err_nx = 1'b1;
            end
        end else if (en) begin
            if (dir) begin
                count_nx = at_max ? '0 : count + ONE;
            end else begin
                count_nx = at_zero ? MAX_VAL : count - ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            err   <= 1'b0;
        end else begin
            count <= count_nx;
            err   <= err_nx;
        end
    end

endmodule

// File: tb/tb_mod_counter_cmp.sv
// Randomized and directed bench for mod_counter_cmp against a modular-arithmetic model.
// Covers up/down counting, load priority, load errors, reset and a full-day cascade.
module tb_mod_counter_cmp;
    import clock_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, en, up, load;
    logic [5:0] load_val;

    logic [5:0] count, count_nd, count_hr;
    logic       tc, carry, err;
    logic       tc_nd, carry_nd, err_nd;
    logic       tc_hr, carry_hr, err_hr;

    logic       c_reset, c_en;
    logic [5:0] cs, cm, ch;
    logic       cs_tc, cs_carry, cs_err;
    logic       cm_tc, cm_carry, cm_err;
    logic       ch_tc, ch_carry, ch_err;

    int checks = 0;
    int errors = 0;

    int m_cnt, m_nd, m_hr;
    bit m_err, m_err_nd, m_err_hr;

    mod_counter_cmp #(.WIDTH(6), .MODULUS(60), .DOWN_EN(1)) u_dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count), .tc(tc), .carry(carry), .err(err)
    );

    mod_counter_cmp #(.WIDTH(6), .MODULUS(60), .DOWN_EN(0)) u_nd (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count_nd), .tc(tc_nd), .carry(carry_nd),
        .err(err_nd)
    );

    mod_counter_cmp #(.WIDTH(6), .MODULUS(24), .DOWN_EN(1)) u_hr (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count_hr), .tc(tc_hr), .carry(carry_hr),
        .err(err_hr)
    );

    mod_counter_cmp #(.WIDTH(CNT_W), .MODULUS(SEC_MIN_MOD)) u_sec (
        .clk(clk), .reset(c_reset), .en(c_en), .up(DIR_UP), .load(1'b0),
        .load_val(6'd0), .count(cs), .tc(cs_tc), .carry(cs_carry), .err(cs_err)
    );

    mod_counter_cmp #(.WIDTH(CNT_W), .MODULUS(SEC_MIN_MOD)) u_min (
        .clk(clk), .reset(c_reset), .en(cs_carry), .up(DIR_UP), .load(1'b0),
        .load_val(6'd0), .count(cm), .tc(cm_tc), .carry(cm_carry), .err(cm_err)
    );

    mod_counter_cmp #(.WIDTH(CNT_W), .MODULUS(HOUR_MOD)) u_hour (
        .clk(clk), .reset(c_reset), .en(cm_carry), .up(DIR_UP), .load(1'b0),
        .load_val(6'd0), .count(ch), .tc(ch_tc), .carry(ch_carry), .err(ch_err)
    );

    function automatic int nxt(input int m, input int md, input bit dir);
        if (reset) return 0;
        if (load) return (int'(load_val) < md) ? int'(load_val) : m;
        if (en) return dir ? (m + 1) % md : (m + md - 1) % md;
        return m;
    endfunction

    function automatic bit nerr(input bit e, input int md);
        if (reset) return 1'b0;
        if (load && int'(load_val) >= md) return 1'b1;
        return e;
    endfunction

    function automatic bit exp_tc(input int m, input int md, input bit dir);
        return dir ? (m == md - 1) : (m == 0);
    endfunction

    task automatic tick();
        int a, b, c;
        bit ea, eb, ec;
        a  = nxt(m_cnt, 60, up);
        b  = nxt(m_nd, 60, 1'b1);
        c  = nxt(m_hr, 24, up);
        ea = nerr(m_err, 60);
        eb = nerr(m_err_nd, 60);
        ec = nerr(m_err_hr, 24);
        @(posedge clk);
        #1;
        m_cnt = a; m_nd = b; m_hr = c;
        m_err = ea; m_err_nd = eb; m_err_hr = ec;
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; load = 1'b0; load_val = '0;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        tick();
        checks++;
        if (count !== 6'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state count=%0d err=%b want 0/0", count, err);
        end
        #1;
        checks++;
        if (tc !== 1'b0 || carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_tc_up tc=%b carry=%b want 0/0", tc, carry);
        end
        up = 1'b0; #1;
        checks++;
        if (tc !== 1'b1 || carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_tc_down tc=%b carry=%b want 1/0", tc, carry);
        end
        en = 1'b1; #1;
        checks++;
        if (carry !== 1'b1) begin
            errors++;
            $display("FAIL reset_carry carry=%b want 1", carry);
        end
        tick();
        checks++;
        if (count !== 6'd0) begin
            errors++;
            $display("FAIL reset_hold count=%0d want 0", count);
        end
        up = 1'b1;
        do_reset();
    endtask

    task automatic test_up_count();
        int pulses = 0;
        do_reset();
        up = 1'b1; en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            #1;
            checks++;
            if (tc !== exp_tc(m_cnt, 60, 1'b1) || carry !== exp_tc(m_cnt, 60, 1'b1)) begin
                errors++;
                $display("FAIL up_tc cnt=%0d tc=%b carry=%b want %b", m_cnt, tc, carry,
                         exp_tc(m_cnt, 60, 1'b1));
            end
            if (carry === 1'b1) pulses++;
            tick();
            checks++;
            if (count !== 6'((i + 1) % 60)) begin
                errors++;
                $display("FAIL up_count got %0d want %0d", count, (i + 1) % 60);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL up_carry_pulses got %0d want 1", pulses);
        end
        en = 1'b0;
    endtask

    task automatic test_down_count();
        do_reset();
        up = 1'b0; en = 1'b1;
        tick();
        checks++;
        if (count !== 6'd59 || count_nd !== 6'd1) begin
            errors++;
            $display("FAIL down_first count=%0d nd=%0d want 59/1", count, count_nd);
        end
        for (int i = 0; i < 62; i++) begin
            #1;
            checks++;
            if (tc !== (m_cnt == 0) || carry !== (m_cnt == 0) || tc_nd !== (m_nd == 59)) begin
                errors++;
                $display("FAIL down_tc cnt=%0d tc=%b carry=%b nd_tc=%b", m_cnt, tc, carry, tc_nd);
            end
            tick();
            checks++;
            if (count !== 6'(m_cnt) || count_nd !== 6'(m_nd)) begin
                errors++;
                $display("FAIL down_count got %0d/%0d want %0d/%0d", count, count_nd, m_cnt, m_nd);
            end
        end
        en = 1'b0; up = 1'b1;
    endtask

    task automatic test_load_en();
        do_reset();
        load = 1'b1; load_val = 6'd59; tick();
        load_val = 6'd45; en = 1'b1; up = 1'b1; #1;
        checks++;
        if (tc !== 1'b1 || carry !== 1'b0) begin
            errors++;
            $display("FAIL load_en_carry tc=%b carry=%b want 1/0", tc, carry);
        end
        tick();
        checks++;
        if (count !== 6'd45 || err !== 1'b0) begin
            errors++;
            $display("FAIL load_en_count count=%0d err=%b want 45/0", count, err);
        end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_out_of_range();
        do_reset();
        load = 1'b1; load_val = 6'd10; tick();
        load_val = 6'd60; tick();
        checks++;
        if (count !== 6'd10 || err !== 1'b1) begin
            errors++;
            $display("FAIL oor_60 count=%0d err=%b want 10/1", count, err);
        end
        load_val = 6'd24; tick();
        checks++;
        if (count_hr !== 6'd10 || err_hr !== 1'b1 || count !== 6'd24) begin
            errors++;
            $display("FAIL oor_24 hr=%0d err_hr=%b cnt=%0d want 10/1/24", count_hr, err_hr, count);
        end
        load_val = 6'd5; tick();
        checks++;
        if (count !== 6'd5 || err !== 1'b1 || err_hr !== 1'b1) begin
            errors++;
            $display("FAIL oor_sticky count=%0d err=%b err_hr=%b want 5/1/1", count, err, err_hr);
        end
        load = 1'b0;
        do_reset();
        checks++;
        if (err !== 1'b0 || err_hr !== 1'b0) begin
            errors++;
            $display("FAIL oor_clear err=%b err_hr=%b want 0/0", err, err_hr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        load = 1'b1; load_val = 6'd37; tick();
        reset = 1'b1; en = 1'b1; load_val = 6'd12; tick();
        checks++;
        if (count !== 6'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid count=%0d err=%b want 0/0", count, err);
        end
        reset = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; #1;
        checks++;
        if (carry !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_carry carry=%b tc=%b want 0/0", carry, tc);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(63) == 0);
            en       = $urandom_range(1);
            up       = $urandom_range(1);
            load     = ($urandom_range(7) == 0);
            load_val = 6'($urandom_range(63));
            #1;
            checks++;
            if (tc !== exp_tc(m_cnt, 60, up) || carry !== (en & exp_tc(m_cnt, 60, up) & ~load)
                || tc_nd !== exp_tc(m_nd, 60, 1'b1) || tc_hr !== exp_tc(m_hr, 24, up)
                || carry_hr !== (en & exp_tc(m_hr, 24, up) & ~load)) begin
                errors++;
                $display("FAIL rand_comb i=%0d tc=%b carry=%b nd=%b hr=%b/%b", i, tc, carry,
                         tc_nd, tc_hr, carry_hr);
            end
            tick();
            checks++;
            if (count !== 6'(m_cnt) || count_nd !== 6'(m_nd) || count_hr !== 6'(m_hr)
                || err !== m_err || err_nd !== m_err_nd || err_hr !== m_err_hr) begin
                errors++;
                $display("FAIL rand_state i=%0d got %0d/%0d/%0d e%b%b%b want %0d/%0d/%0d e%b%b%b",
                         i, count, count_nd, count_hr, err, err_nd, err_hr,
                         m_cnt, m_nd, m_hr, m_err, m_err_nd, m_err_hr);
            end
        end
        reset = 1'b0; en = 1'b0; load = 1'b0;
    endtask

    task automatic test_cascade();
        int bad = 0, steps = 0, bad_step = 0, first_zero = 0;
        logic [5:0] prev_min;
        c_reset = 1'b1; c_en = 1'b0;
        @(posedge clk); #1;
        c_reset = 1'b0;
        checks++;
        if (cs !== 6'd0 || cm !== 6'd0 || ch !== 6'd0) begin
            errors++;
            $display("FAIL cascade_reset got %0d:%0d:%0d want 0:0:0", ch, cm, cs);
        end
        c_en = 1'b1;
        for (int t = 1; t <= 86400; t++) begin
            prev_min = cm;
            @(posedge clk); #1;
            if (cs !== 6'(t % 60) || cm !== 6'((t / 60) % 60) || ch !== 6'((t / 3600) % 24))
                bad++;
            if (cm !== prev_min) begin
                steps++;
                if (cs !== 6'd0) bad_step++;
            end
            if (first_zero == 0 && cs === 6'd0 && cm === 6'd0 && ch === 6'd0)
                first_zero = t;
        end
        c_en = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL cascade_track bad_cycles=%0d want 0", bad);
        end
        checks++;
        if (steps != 1440 || bad_step != 0) begin
            errors++;
            $display("FAIL cascade_min_steps got %0d (misaligned %0d) want 1440 (0)", steps, bad_step);
        end
        checks++;
        if (first_zero != 86400) begin
            errors++;
            $display("FAIL cascade_wrap first_all_zero=%0d want 86400", first_zero);
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        c_reset = 1'b1; c_en = 1'b0;
        m_cnt = 0; m_nd = 0; m_hr = 0;
        m_err = 0; m_err_nd = 0; m_err_hr = 0;
        #2;
        test_reset();
        test_up_count();
        test_down_count();
        test_load_en();
        test_out_of_range();
        test_reset_mid();
        test_random();
        test_cascade();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
